egress_arbiter: RTL and testbench

- Frame-granular round-robin scheduler that shares one egress MII transmit path among NUM_PORTS ingress byte FIFOs.
- Selects one FIFO, streams a whole frame from it to the transmit serializer with a valid/ready handshake, then enforces an inter-frame gap.
- Bounds frame length, truncating and discarding runaway frames.
- Sits between the per-port receive FIFOs (transceiver side) and the egress MII transmit serializer.

---
 rtl/egress_arbiter.sv | 177 +++++++++++++++++
 tb/tb_egress_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_arbiter.sv
// egress_arbiter: frame-granular round-robin scheduler sharing one egress MII
// transmit path among NUM_PORTS first-word-fall-through ingress byte FIFOs.
// Streams a whole frame from the granted FIFO, truncates frames longer than
// MAX_BYTES (remaining bytes are popped and discarded), then holds an
// inter-frame gap of IFG_CYCLES before the next frame may start.
//
// Ports:
//   clock, reset          single clock, asynchronous active-low reset
//   in_empty/data/last    per-FIFO head status, byte and end-of-frame flag
//   in_read_enable        per-FIFO pop strobe (one-hot or zero)
//   tx_data/valid/last    byte stream to the serializer (valid/ready)
//   tx_error              marks the final byte of a truncated frame
//   tx_ready              serializer accepts the byte this cycle
//   grant                 one-hot current owner, zero when idle or in gap
//   busy                  scheduler is not idle
module egress_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MAX_BYTES  = 1522
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       in_empty,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]       in_last,
  output logic [NUM_PORTS-1:0]       in_read_enable,
  output logic [WIDTH-1:0]           tx_data,
  output logic                       tx_valid,
  output logic                       tx_last,
  output logic                       tx_error,
  input  logic                       tx_ready,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       busy
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = $clog2(MAX_BYTES + 1);
  localparam int unsigned GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DROP, GAP} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        byte_count_q, byte_count_d;
  logic [GW-1:0]        gap_count_q, gap_count_d;

  logic                 req_found;
  logic [PW-1:0]        req_port;
  logic [PW-1:0]        cand;
  logic                 head_empty;
  logic                 head_last;
  logic [WIDTH-1:0]     head_data;
  logic                 trunc;

  // Head of the owning FIFO
  assign head_empty = in_empty[owner_q];
  assign head_last  = in_last[owner_q];
  assign head_data  = in_data[owner_q*WIDTH +: WIDTH];
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);

  // Round-robin search starting one past the last granted port
  always_comb begin
    req_found = 1'b0;
    req_port  = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((32'(rr_q) + k) % NUM_PORTS);
      if (!req_found && !in_empty[cand]) begin
        req_found = 1'b1;
        req_port  = cand;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_d        = owner_q;
    rr_d           = rr_q;
    byte_count_d   = byte_count_q;
    gap_count_d    = gap_count_q;
    tx_valid       = 1'b0;
    tx_data        = '0;
    tx_last        = 1'b0;
    tx_error       = 1'b0;
    in_read_enable = '0;
    trunc          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d = STREAM;
          grant_d = NUM_PORTS'(1) << req_port;
          owner_d = req_port;
          rr_d    = req_port;
        end
      end

      STREAM: begin
        tx_valid = !head_empty;
        tx_data  = head_data;
        trunc    = (byte_count_q == CW'(MAX_BYTES - 1)) && !head_last;
        tx_last  = tx_valid && (head_last || trunc);
        tx_error = tx_valid && trunc;
        if (tx_valid && tx_ready) begin
          in_read_enable = grant_q;
          if (head_last) begin
            state_d      = GAP;
            grant_d      = '0;
            byte_count_d = '0;
          end else if (trunc) begin
            state_d      = DROP;
            byte_count_d = '0;
          end else begin
            byte_count_d = byte_count_q + CW'(1);
          end
        end
      end

      // Discard the rest of a truncated frame without forwarding
      DROP: begin
        if (!head_empty) begin
          in_read_enable = grant_q;
          if (head_last) begin
            state_d = GAP;
            grant_d = '0;
          end
        end
      end

      // The last gap cycle doubles as an arbitration cycle so that the next
      // frame starts exactly IFG_CYCLES idle cycles after the previous one.
      GAP: begin
        if (gap_count_q == GW'(IFG_CYCLES - 1)) begin
          gap_count_d = '0;
          if (req_found) begin
            state_d = STREAM;
            grant_d = NUM_PORTS'(1) << req_port;
            owner_d = req_port;
            rr_d    = req_port;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_count_d = gap_count_q + GW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_q         <= PW'(NUM_PORTS - 1);
      byte_count_q <= '0;
      gap_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      byte_count_q <= byte_count_d;
      gap_count_q  <= gap_count_d;
    end
  end

endmodule

// File: tb/tb_egress_arbiter.sv
// Testbench for egress_arbiter: FIFO models drive the inputs, accepted bytes
// are collected and compared against a frame-level round-robin model.
module tb_egress_arbiter;

  localparam int unsigned NP   = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned IFG  = 12;
  localparam int unsigned MAXB = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [NP-1:0]   in_empty;
  logic [NP*W-1:0] in_data;
  logic [NP-1:0]   in_last;
  logic [NP-1:0]   in_read_enable;
  logic [W-1:0]    tx_data;
  logic            tx_valid;
  logic            tx_last;
  logic            tx_error;
  logic            tx_ready;
  logic [NP-1:0]   grant;
  logic            busy;

  egress_arbiter #(
    .NUM_PORTS(NP), .WIDTH(W), .IFG_CYCLES(IFG), .MAX_BYTES(MAXB)
  ) dut (
    .clock(clock), .reset(reset),
    .in_empty(in_empty), .in_data(in_data), .in_last(in_last),
    .in_read_enable(in_read_enable),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_error(tx_error), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
    logic       err;
    int         cyc;
  } rec_t;

  logic [8:0] fifo_q [NP][$];
  rec_t       obs_q[$];
  rec_t       exp_q[$];
  int         ready_pat[$];
  bit         rand_ready;
  int         total, bad, cyc_n, model_rr;

  logic [NP-1:0] s_re, s_grant;
  logic          s_valid, s_last, s_err, s_busy, s_ready;
  logic [7:0]    s_data;
  logic          p_valid, p_ready, p_last;
  logic [7:0]    p_data;

  function automatic int port_of(logic [NP-1:0] g);
    int r = -1;
    for (int p = 0; p < NP; p++) if (g[p]) r = p;
    return r;
  endfunction

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int p = 0; p < NP; p++) if (fifo_q[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive_heads();
    logic [8:0] h;
    for (int p = 0; p < NP; p++) begin
      if (fifo_q[p].size() > 0) begin
        h = fifo_q[p][0];
        in_empty[p]      = 1'b0;
        in_data[p*W +: W] = h[7:0];
        in_last[p]       = h[8];
      end else begin
        in_empty[p]      = 1'b1;
        in_data[p*W +: W] = '0;
        in_last[p]       = 1'b0;
      end
    end
  endtask

  task automatic load_frame(input int port, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      fifo_q[port].push_back({(i == len - 1) ? 1'b1 : 1'b0, b});
    end
  endtask

  // Capture outputs mid-cycle and check the per-cycle handshake rules
  task automatic sample();
    logic [NP-1:0] exp_re;
    p_valid = s_valid; p_ready = s_ready; p_data = s_data; p_last = s_last;
    s_re = in_read_enable; s_grant = grant; s_valid = tx_valid;
    s_last = tx_last; s_err = tx_error; s_busy = busy; s_ready = tx_ready;
    s_data = tx_data;
    if (s_valid && s_ready)
      obs_q.push_back('{port_of(s_grant), s_data, s_last, s_err, cyc_n});
    total++;
    if (!$onehot0(s_re) || (s_re & ~s_grant) != '0 || (s_re & in_empty) != '0) begin
      bad++;
      $display("FAIL pop_owner cyc%0d: re=%b grant=%b empty=%b", cyc_n, s_re, s_grant, in_empty);
    end
    if (s_valid) begin
      total++;
      exp_re = s_ready ? s_grant : '0;
      if (s_re !== exp_re) begin
        bad++;
        $display("FAIL pop_handshake cyc%0d: re=%b want %b", cyc_n, s_re, exp_re);
      end
    end
    if (p_valid && !p_ready) begin
      total++;
      if (s_valid !== 1'b1 || s_data !== p_data || s_last !== p_last) begin
        bad++;
        $display("FAIL stall_stable cyc%0d: v=%b d=%h l=%b want v=1 d=%h l=%b",
                 cyc_n, s_valid, s_data, s_last, p_data, p_last);
      end
    end
    if (s_err) begin
      total++;
      if (s_last !== 1'b1) begin
        bad++;
        $display("FAIL err_needs_last cyc%0d: last=%b want 1", cyc_n, s_last);
      end
    end
  endtask

  // One clock: apply pops seen last cycle, drive new inputs, sample outputs
  task automatic cyc();
    @(posedge clock);
    #1;
    for (int p = 0; p < NP; p++)
      if (s_re[p] && fifo_q[p].size() > 0) void'(fifo_q[p].pop_front());
    if (ready_pat.size() > 0) tx_ready = (ready_pat.pop_front() != 0);
    else if (rand_ready)      tx_ready = ($urandom_range(0, 3) != 0);
    else                      tx_ready = 1'b1;
    drive_heads();
    cyc_n++;
    @(negedge clock);
    sample();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    cyc();
    while (s_busy || !all_empty()) begin
      cyc();
      n++;
      if (n > 3000) break;
    end
    total++;
    if (n > 3000) begin
      bad++;
      $display("FAIL %s timeout: busy=%b fifos_empty=%b want idle", name, s_busy, all_empty());
    end
  endtask

  // Frame-level reference: whole frames in round-robin order, truncated at MAXB
  task automatic build_expected();
    logic [8:0] m [NP][$];
    logic [8:0] e;
    int sel, n;
    bit done;
    exp_q.delete();
    for (int p = 0; p < NP; p++) m[p] = fifo_q[p];
    forever begin
      sel = -1;
      for (int k = 1; k <= NP; k++)
        if (sel < 0 && m[(model_rr + k) % NP].size() > 0) sel = (model_rr + k) % NP;
      if (sel < 0) break;
      model_rr = sel;
      n = 0;
      done = 1'b0;
      while (!done && m[sel].size() > 0) begin
        e = m[sel].pop_front();
        n++;
        if (e[8]) begin
          exp_q.push_back('{sel, e[7:0], 1'b1, 1'b0, 0});
          done = 1'b1;
        end else if (n == MAXB) begin
          exp_q.push_back('{sel, e[7:0], 1'b1, 1'b1, 0});
          while (!done && m[sel].size() > 0) begin
            e = m[sel].pop_front();
            done = e[8];
          end
          done = 1'b1;
        end else begin
          exp_q.push_back('{sel, e[7:0], 1'b0, 1'b0, 0});
        end
      end
    end
  endtask

  task automatic compare_stream(input string name);
    int n;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_len: got %0d bytes want %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_q[i].port != exp_q[i].port || obs_q[i].data !== exp_q[i].data ||
          obs_q[i].last !== exp_q[i].last || obs_q[i].err !== exp_q[i].err) begin
        bad++;
        $display("FAIL %s byte%0d: got p%0d %h l%b e%b want p%0d %h l%b e%b", name, i,
                 obs_q[i].port, obs_q[i].data, obs_q[i].last, obs_q[i].err,
                 exp_q[i].port, exp_q[i].data, exp_q[i].last, exp_q[i].err);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({tx_valid, tx_last, tx_error, tx_data, grant, busy, in_read_enable} !== '0) begin
      bad++;
      $display("FAIL %s: v=%b l=%b e=%b d=%h g=%b busy=%b re=%b want all 0", name,
               tx_valid, tx_last, tx_error, tx_data, grant, busy, in_read_enable);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset_outputs");
    reset = 1'b1;
    model_rr = NP - 1;
    cyc();
  endtask

  task automatic test_single_frame();
    logic [7:0] bytes [3];
    logic [NP+W+3:0] act, expv;
    bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'hD5;
    obs_q.delete();
    for (int i = 0; i < 3; i++) fifo_q[2].push_back({(i == 2) ? 1'b1 : 1'b0, bytes[i]});
    for (int i = 0; i <= 16; i++) begin
      cyc();
      if (i >= 1 && i <= 3)
        expv = {4'b0100, 1'b1, bytes[i-1], (i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b1};
      else
        expv = {4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, (i >= 4 && i <= 15) ? 1'b1 : 1'b0};
      act = {s_grant, s_valid, s_valid ? s_data : 8'h00, s_last, s_err, s_busy};
      total++;
      if (act !== expv) begin
        bad++;
        $display("FAIL single_frame step%0d: {g,v,d,l,e,busy}=%h want %h", i, act, expv);
      end
    end
    model_rr = 2;
  endtask

  task automatic test_three_ports();
    obs_q.delete();
    load_frame(0, 2); load_frame(1, 2); load_frame(3, 2);
    build_expected();
    wait_idle("three_ports");
    compare_stream("three_ports");
    for (int i = 1; i < obs_q.size(); i++) begin
      if (obs_q[i-1].last) begin
        total++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != IFG + 1) begin
          bad++;
          $display("FAIL ifg_spacing: got %0d cycles want %0d",
                   obs_q[i].cyc - obs_q[i-1].cyc, IFG + 1);
        end
      end
    end
  endtask

  task automatic test_priority();
    obs_q.delete();
    load_frame(1, 3);
    build_expected();
    wait_idle("priority_first");
    compare_stream("priority_first");
    obs_q.delete();
    load_frame(0, 2); load_frame(1, 2);
    build_expected();
    wait_idle("priority_second");
    compare_stream("priority_second");
    total++;
    if (obs_q.size() == 0 || obs_q[0].port != 0) begin
      bad++;
      $display("FAIL priority_winner: got port %0d want 0", (obs_q.size() > 0) ? obs_q[0].port : -1);
    end
  endtask

  task automatic test_backpressure();
    obs_q.delete();
    load_frame(2, 4);
    build_expected();
    ready_pat.push_back(1);
    for (int r = 0; r < 4; r++) begin
      ready_pat.push_back(1); ready_pat.push_back(0);
      ready_pat.push_back(0); ready_pat.push_back(1);
    end
    wait_idle("backpressure");
    ready_pat.delete();
    compare_stream("backpressure");
  endtask

  task automatic test_truncate();
    obs_q.delete();
    load_frame(0, 20);
    build_expected();
    wait_idle("truncate");
    compare_stream("truncate");
    total++;
    if (obs_q.size() != MAXB || !obs_q[obs_q.size()-1].err || !obs_q[obs_q.size()-1].last) begin
      bad++;
      $display("FAIL truncate_tail: got %0d bytes want %0d with last+error on final", obs_q.size(), MAXB);
    end
  endtask

  task automatic test_random();
    int nload;
    rand_ready = 1'b1;
    for (int round = 0; round < 8; round++) begin
      obs_q.delete();
      nload = 0;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 9) < 6) begin
          load_frame(p, $urandom_range(1, 12));
          nload++;
          if ($urandom_range(0, 1) == 1) load_frame(p, $urandom_range(1, 12));
        end
      end
      if (nload == 0) load_frame($urandom_range(0, NP - 1), $urandom_range(1, 12));
      build_expected();
      wait_idle("random");
      compare_stream("random");
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    obs_q.delete();
    load_frame(1, 10);
    while (obs_q.size() < 3 && n < 50) begin
      cyc();
      n++;
    end
    total++;
    if (obs_q.size() < 3) begin
      bad++;
      $display("FAIL midframe_reach: got %0d bytes want 3", obs_q.size());
    end
    reset = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    for (int p = 0; p < NP; p++) fifo_q[p].delete();
    obs_q.delete();
    s_re = '0; s_valid = 1'b0;
    model_rr = NP - 1;
    drive_heads();
    cyc();
    cyc();
    reset = 1'b1;
    load_frame(0, 3); load_frame(2, 3);
    build_expected();
    wait_idle("after_reset");
    compare_stream("after_reset");
    total++;
    if (obs_q.size() == 0 || obs_q[0].port != 0) begin
      bad++;
      $display("FAIL restart_port: got port %0d want 0", (obs_q.size() > 0) ? obs_q[0].port : -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc_n = 0; model_rr = NP - 1;
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    s_re = '0; s_grant = '0; s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
    s_busy = 1'b0; s_ready = 1'b0; s_data = '0;
    in_empty = '1; in_data = '0; in_last = '0;
    drive_heads();
    test_reset();
    test_single_frame();
    test_three_ports();
    test_priority();
    test_backpressure();
    test_truncate();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
